// File: rtl/leitor_tabuleiro_pkg.sv
// Shared encodings for the micro-board reader: cell and result codes, FSM states
// and the table of the eight tic-tac-toe lines.
package leitor_tabuleiro_pkg;

    localparam int unsigned N_CELULAS = 9;

    localparam logic [1:0] VAZIO = 2'b00;
    localparam logic [1:0] CEL_X = 2'b01;
    localparam logic [1:0] CEL_O = 2'b10;

    typedef enum logic [1:0] {
        RES_NADA   = 2'b00,
        RES_X      = 2'b01,
        RES_O      = 2'b10,
        RES_EMPATE = 2'b11
    } resultado_t;

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        LE     = 3'd1,
        ULTIMA = 3'd2,
        AVALIA = 3'd3,
        PRONTO = 3'd4
    } estado_t;

    // Rows, then columns, then the two diagonals; the index is the reported line number.
    localparam logic [3:0] LINHAS [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

endpackage

// File: rtl/leitor_tabuleiro_if.sv
// Request/response and board-RAM read bus of the micro-board reader.
interface leitor_tabuleiro_if;

    logic       iniciar_leitura;
    logic [3:0] macro_idx;
    logic [1:0] ram_dado;
    logic [6:0] ram_addr;
    logic       ram_re;
    logic [1:0] resultado;
    logic       pronto;
    logic       ocupado;
    logic [3:0] db_estado;

    modport master (
        output iniciar_leitura, macro_idx, ram_dado,
        input  ram_addr, ram_re, resultado, pronto, ocupado, db_estado
    );

    modport slave (
        input  iniciar_leitura, macro_idx, ram_dado,
        output ram_addr, ram_re, resultado, pronto, ocupado, db_estado
    );

endinterface

// File: rtl/leitor_tabuleiro_avaliador_linhas.sv
// Combinational evaluation of a captured 3x3 board; LEITOR_LINHA_EN adds the
// index of the lowest winning line of the reported winner.
module avaliador_linhas
    import leitor_tabuleiro_pkg::*;
(
    input  logic [8:0][1:0] tabuleiro,
`ifdef LEITOR_LINHA_EN
    output logic [2:0]      linha,
`endif
    output resultado_t      resultado
);

    logic       x_ganha;
    logic       o_ganha;
    logic       cheio;
`ifdef LEITOR_LINHA_EN
    logic [2:0] x_linha;
    logic [2:0] o_linha;
`endif

    // NOTE: every variable gets a default before the loops, so no latch is inferred.
    always_comb begin
        x_ganha = 1'b0;
        o_ganha = 1'b0;
        cheio   = 1'b1;
`ifdef LEITOR_LINHA_EN
        x_linha = 3'd0;
        o_linha = 3'd0;
`endif
        // Walk downwards so the last hit written is the lowest-numbered line.
        for (int l = 7; l >= 0; l--) begin
            if (tabuleiro[LINHAS[3'(l)][0]] == CEL_X && tabuleiro[LINHAS[3'(l)][1]] == CEL_X &&
                tabuleiro[LINHAS[3'(l)][2]] == CEL_X) begin
                x_ganha = 1'b1;
`ifdef LEITOR_LINHA_EN
                x_linha = 3'(l);
`endif
            end
            if (tabuleiro[LINHAS[3'(l)][0]] == CEL_O && tabuleiro[LINHAS[3'(l)][1]] == CEL_O &&
                tabuleiro[LINHAS[3'(l)][2]] == CEL_O) begin
                o_ganha = 1'b1;
`ifdef LEITOR_LINHA_EN
                o_linha = 3'(l);
`endif
            end
        end
        for (int c = 0; c < 9; c++) begin
            if (tabuleiro[4'(c)] != CEL_X && tabuleiro[4'(c)] != CEL_O) cheio = 1'b0;
        end

        if (x_ganha)      resultado = RES_X;
        else if (o_ganha) resultado = RES_O;
        else if (cheio)   resultado = RES_EMPATE;
        else              resultado = RES_NADA;
`ifdef LEITOR_LINHA_EN
        linha = x_ganha ? x_linha : (o_ganha ? o_linha : 3'd0);
`endif
    end

endmodule

// File: rtl/leitor_tabuleiro.sv
// Reads the nine cells of one micro board from the board RAM and reports the
// game result. Optional macro LEITOR_LINHA_EN adds linha_idx/linha_valida outputs.
module leitor_tabuleiro
    import leitor_tabuleiro_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    leitor_tabuleiro_if.slave bus
`ifdef LEITOR_LINHA_EN
    ,
    output logic [2:0]        linha_idx,
    output logic [0:0]        linha_valida
`endif
);

    estado_t         estado, prox;
    logic [3:0]      idx;
    logic [3:0]      cnt;
    logic [8:0][1:0] celulas;
    resultado_t      resultado_q;
    resultado_t      res_aval;
    logic [6:0]      base;
`ifdef LEITOR_LINHA_EN
    logic [2:0]      linha_aval;
`endif

    assign base          = 7'({idx, 3'b000}) + 7'(idx);
    assign bus.resultado = resultado_q;

    avaliador_linhas u_avaliador (
        .tabuleiro (celulas),
`ifdef LEITOR_LINHA_EN
        .linha     (linha_aval),
`endif
        .resultado (res_aval)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= OCIOSO;
        else        estado <= prox;
    end

    always_comb begin
        prox          = estado;
        bus.ram_re    = 1'b0;
        bus.ram_addr  = 7'd0;
        bus.pronto    = 1'b0;
        bus.ocupado   = 1'b1;
        bus.db_estado = {1'b0, estado};
        case (estado)
            OCIOSO: begin
                bus.ocupado = 1'b0;
                if (bus.iniciar_leitura) prox = (bus.macro_idx <= 4'd8) ? LE : PRONTO;
            end
            LE: begin
                bus.ram_re   = 1'b1;
                bus.ram_addr = base + 7'(cnt);
                if (cnt == 4'(N_CELULAS - 1)) prox = ULTIMA;
            end
            ULTIMA: prox = AVALIA;
            AVALIA: prox = PRONTO;
            PRONTO: begin
                bus.pronto = 1'b1;
                prox       = OCIOSO;
            end
            default: begin
                prox          = OCIOSO;
                bus.ocupado   = 1'b0;
                bus.db_estado = 4'hE;
            end
        endcase
    end

    // NOTE: the nine cell registers form a small register file that is still reset,
    // so a read aborted by reset never leaves stale cells behind.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx          <= 4'd0;
            cnt          <= 4'd0;
            celulas      <= '0;
            resultado_q  <= RES_NADA;
`ifdef LEITOR_LINHA_EN
            linha_idx    <= 3'd0;
            linha_valida <= 1'b0;
`endif
        end else begin
            case (estado)
                OCIOSO: begin
                    if (bus.iniciar_leitura) begin
                        if (bus.macro_idx <= 4'd8) begin
                            idx <= bus.macro_idx;
                            cnt <= 4'd0;
                        end else begin
                            resultado_q  <= RES_NADA;
`ifdef LEITOR_LINHA_EN
                            linha_idx    <= 3'd0;
                            linha_valida <= 1'b0;
`endif
                        end
                    end
                end
                LE: begin
                    // RAM data lags the address by one cycle.
                    if (cnt != 4'd0) celulas[cnt - 4'd1] <= bus.ram_dado;
                    if (cnt != 4'(N_CELULAS - 1)) cnt <= cnt + 4'd1;
                end
                ULTIMA: celulas[8] <= bus.ram_dado;
                AVALIA: begin
                    resultado_q  <= res_aval;
`ifdef LEITOR_LINHA_EN
                    linha_idx    <= linha_aval;
                    linha_valida <= (res_aval == RES_X) || (res_aval == RES_O);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_leitor_tabuleiro.sv
// Directed bench for leitor_tabuleiro with a synchronous-read board RAM model;
// also checks linha_idx/linha_valida when LEITOR_LINHA_EN is defined.
module tb_leitor_tabuleiro;

    localparam int CICLOS = 13;

    logic clock;
    logic reset;
    leitor_tabuleiro_if bus ();
`ifdef LEITOR_LINHA_EN
    logic [2:0] linha_idx;
    logic [0:0] linha_valida;
`endif

    leitor_tabuleiro dut (
        .clock (clock),
        .reset (reset),
`ifdef LEITOR_LINHA_EN
        .linha_idx    (linha_idx),
        .linha_valida (linha_valida),
`endif
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [1:0] mem [0:80];

    // One-cycle synchronous-read board RAM.
    always @(posedge clock or negedge reset) begin
        if (!reset)                    bus.ram_dado <= 2'b00;
        else if (bus.ram_re === 1'b1)  bus.ram_dado <= mem[bus.ram_addr];
    end

    int vectors    = 0;
    int miscompares = 0;

    logic [6:0] addr_log [1:CICLOS];
    logic       re_log   [1:CICLOS];
    logic [3:0] est_log  [1:CICLOS];
    logic       oc_log   [1:CICLOS];
    int         pronto_ciclo;
    int         pronto_qtd;
    logic [1:0] res_pronto;
    logic [2:0] linha_pronto;
    logic       valida_pronto;

    // Starts a read at the current falling edge and logs CICLOS cycles of outputs.
    task automatic ler(input logic [3:0] idx, input int recomeco, input logic [3:0] idx_recomeco);
        bus.iniciar_leitura = 1'b1;
        bus.macro_idx       = idx;
        pronto_ciclo = -1;
        pronto_qtd   = 0;
        res_pronto   = 2'bxx;
        linha_pronto = 3'bxxx;
        valida_pronto = 1'bx;
        for (int c = 1; c <= CICLOS; c++) begin
            @(negedge clock);
            addr_log[c] = bus.ram_addr;
            re_log[c]   = bus.ram_re;
            est_log[c]  = bus.db_estado;
            oc_log[c]   = bus.ocupado;
            if (bus.pronto === 1'b1) begin
                pronto_qtd++;
                if (pronto_ciclo < 0) begin
                    pronto_ciclo = c;
                    res_pronto   = bus.resultado;
`ifdef LEITOR_LINHA_EN
                    linha_pronto  = linha_idx;
                    valida_pronto = linha_valida[0];
`endif
                end
            end
            bus.iniciar_leitura = (c == recomeco);
            if (c == recomeco) bus.macro_idx = idx_recomeco;
        end
        bus.iniciar_leitura = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.iniciar_leitura = 1'b0;
        bus.macro_idx = 4'd0;
        #12;
        vectors++;
        if (bus.ram_addr !== 7'd0 || bus.ram_re !== 1'b0 || bus.resultado !== 2'b00 ||
            bus.pronto !== 1'b0 || bus.ocupado !== 1'b0 || bus.db_estado !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got addr=%0d re=%b res=%b pronto=%b ocup=%b est=%0h, expected all zero",
                     bus.ram_addr, bus.ram_re, bus.resultado, bus.pronto, bus.ocupado, bus.db_estado);
        end
`ifdef LEITOR_LINHA_EN
        vectors++;
        if (linha_idx !== 3'd0 || linha_valida !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_linha: got idx=%0d valida=%b, expected 0/0", linha_idx, linha_valida);
        end
`endif
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_linha_x();
        ler(4'd4, 0, 4'd0);
        for (int c = 1; c <= 9; c++) begin
            vectors++;
            if (re_log[c] !== 1'b1 || addr_log[c] !== 7'(36 + c - 1)) begin
                miscompares++;
                $display("FAIL x_addr c%0d: got re=%b addr=%0d, expected re=1 addr=%0d", c, re_log[c], addr_log[c], 36 + c - 1);
            end
        end
        vectors++;
        if (re_log[10] !== 1'b0 || re_log[11] !== 1'b0 || re_log[12] !== 1'b0) begin
            miscompares++;
            $display("FAIL x_re_off: got re10..12=%b%b%b, expected 000", re_log[10], re_log[11], re_log[12]);
        end
        vectors++;
        if (est_log[1] !== 4'd1 || est_log[10] !== 4'd2 || est_log[11] !== 4'd3 ||
            est_log[12] !== 4'd4 || est_log[13] !== 4'd0) begin
            miscompares++;
            $display("FAIL x_estados: got %0h %0h %0h %0h %0h, expected 1 2 3 4 0",
                     est_log[1], est_log[10], est_log[11], est_log[12], est_log[13]);
        end
        vectors++;
        if (oc_log[1] !== 1'b1 || oc_log[12] !== 1'b1 || oc_log[13] !== 1'b0) begin
            miscompares++;
            $display("FAIL x_ocupado: got c1=%b c12=%b c13=%b, expected 1 1 0", oc_log[1], oc_log[12], oc_log[13]);
        end
        vectors++;
        if (pronto_ciclo != 12 || pronto_qtd != 1 || res_pronto !== 2'b01) begin
            miscompares++;
            $display("FAIL x_resultado: got pronto cycle %0d count %0d res=%b, expected cycle 12 count 1 res=01",
                     pronto_ciclo, pronto_qtd, res_pronto);
        end
`ifdef LEITOR_LINHA_EN
        vectors++;
        if (linha_pronto !== 3'd0 || valida_pronto !== 1'b1) begin
            miscompares++;
            $display("FAIL x_linha: got idx=%0d valida=%b, expected 0/1", linha_pronto, valida_pronto);
        end
`endif
    endtask

    task automatic test_linha_o();
        ler(4'd8, 0, 4'd0);
        for (int c = 1; c <= 9; c++) begin
            vectors++;
            if (re_log[c] !== 1'b1 || addr_log[c] !== 7'(72 + c - 1)) begin
                miscompares++;
                $display("FAIL o_addr c%0d: got re=%b addr=%0d, expected re=1 addr=%0d", c, re_log[c], addr_log[c], 72 + c - 1);
            end
        end
        vectors++;
        if (pronto_ciclo != 12 || pronto_qtd != 1 || res_pronto !== 2'b10) begin
            miscompares++;
            $display("FAIL o_resultado: got cycle %0d count %0d res=%b, expected cycle 12 count 1 res=10",
                     pronto_ciclo, pronto_qtd, res_pronto);
        end
`ifdef LEITOR_LINHA_EN
        vectors++;
        if (linha_pronto !== 3'd7 || valida_pronto !== 1'b1) begin
            miscompares++;
            $display("FAIL o_linha: got idx=%0d valida=%b, expected 7/1", linha_pronto, valida_pronto);
        end
`endif
    endtask

    task automatic test_prioridade();
        ler(4'd3, 0, 4'd0);
        vectors++;
        if (pronto_ciclo != 12 || res_pronto !== 2'b01) begin
            miscompares++;
            $display("FAIL prioridade_x: got cycle %0d res=%b, expected cycle 12 res=01", pronto_ciclo, res_pronto);
        end
`ifdef LEITOR_LINHA_EN
        vectors++;
        if (linha_pronto !== 3'd1 || valida_pronto !== 1'b1) begin
            miscompares++;
            $display("FAIL prioridade_linha: got idx=%0d valida=%b, expected 1/1", linha_pronto, valida_pronto);
        end
`endif
    endtask

    task automatic test_indice_invalido();
        int re_qtd;
        ler(4'd9, 0, 4'd0);
        re_qtd = 0;
        for (int c = 1; c <= CICLOS; c++) if (re_log[c] !== 1'b0) re_qtd++;
        vectors++;
        if (re_qtd != 0) begin
            miscompares++;
            $display("FAIL invalido_re: got %0d cycles with ram_re, expected 0", re_qtd);
        end
        vectors++;
        if (pronto_ciclo != 1 || pronto_qtd != 1 || res_pronto !== 2'b00 || est_log[2] !== 4'd0) begin
            miscompares++;
            $display("FAIL invalido_pronto: got cycle %0d count %0d res=%b est2=%0h, expected cycle 1 count 1 res=00 est2=0",
                     pronto_ciclo, pronto_qtd, res_pronto, est_log[2]);
        end
`ifdef LEITOR_LINHA_EN
        vectors++;
        if (valida_pronto !== 1'b0) begin
            miscompares++;
            $display("FAIL invalido_linha: got valida=%b, expected 0", valida_pronto);
        end
`endif
    endtask

    task automatic test_empate();
        ler(4'd0, 0, 4'd0);
        vectors++;
        if (pronto_ciclo != 12 || res_pronto !== 2'b11) begin
            miscompares++;
            $display("FAIL empate: got cycle %0d res=%b, expected cycle 12 res=11", pronto_ciclo, res_pronto);
        end
`ifdef LEITOR_LINHA_EN
        vectors++;
        if (valida_pronto !== 1'b0) begin
            miscompares++;
            $display("FAIL empate_linha: got valida=%b, expected 0", valida_pronto);
        end
`endif
        mem[8] = 2'b11;
        ler(4'd0, 0, 4'd0);
        vectors++;
        if (pronto_ciclo != 12 || res_pronto !== 2'b00) begin
            miscompares++;
            $display("FAIL celula_invalida: got cycle %0d res=%b, expected cycle 12 res=00", pronto_ciclo, res_pronto);
        end
    endtask

    task automatic test_inicio_ignorado();
        ler(4'd8, 5, 4'd2);
        for (int c = 1; c <= 9; c++) begin
            vectors++;
            if (re_log[c] !== 1'b1 || addr_log[c] !== 7'(72 + c - 1)) begin
                miscompares++;
                $display("FAIL ignorado_addr c%0d: got re=%b addr=%0d, expected re=1 addr=%0d", c, re_log[c], addr_log[c], 72 + c - 1);
            end
        end
        vectors++;
        if (pronto_ciclo != 12 || pronto_qtd != 1 || res_pronto !== 2'b10) begin
            miscompares++;
            $display("FAIL ignorado_resultado: got cycle %0d count %0d res=%b, expected cycle 12 count 1 res=10",
                     pronto_ciclo, pronto_qtd, res_pronto);
        end
    endtask

    task automatic test_back_to_back();
        ler(4'd4, 12, 4'd2);
        vectors++;
        if (pronto_ciclo != 12 || est_log[13] !== 4'd0 || re_log[13] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_pronto_ignora: got pronto cycle %0d est13=%0h re13=%b, expected 12 0 0",
                     pronto_ciclo, est_log[13], re_log[13]);
        end
        ler(4'd3, 0, 4'd0);
        vectors++;
        if (est_log[1] !== 4'd1 || addr_log[1] !== 7'd27 || addr_log[9] !== 7'd35) begin
            miscompares++;
            $display("FAIL b2b_reinicio: got est1=%0h addr1=%0d addr9=%0d, expected 1 27 35", est_log[1], addr_log[1], addr_log[9]);
        end
        vectors++;
        if (pronto_ciclo != 12 || res_pronto !== 2'b01) begin
            miscompares++;
            $display("FAIL b2b_resultado: got cycle %0d res=%b, expected cycle 12 res=01", pronto_ciclo, res_pronto);
        end
    endtask

    task automatic test_reset_meio();
        int pr_qtd;
        bus.iniciar_leitura = 1'b1;
        bus.macro_idx = 4'd4;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            bus.iniciar_leitura = 1'b0;
        end
        vectors++;
        if (bus.db_estado !== 4'd1 || bus.ram_addr !== 7'd41) begin
            miscompares++;
            $display("FAIL meio_antes: got est=%0h addr=%0d, expected 1 41", bus.db_estado, bus.ram_addr);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.ram_addr !== 7'd0 || bus.ram_re !== 1'b0 || bus.resultado !== 2'b00 ||
            bus.pronto !== 1'b0 || bus.ocupado !== 1'b0 || bus.db_estado !== 4'd0) begin
            miscompares++;
            $display("FAIL meio_reset: got addr=%0d re=%b res=%b pronto=%b ocup=%b est=%0h, expected all zero",
                     bus.ram_addr, bus.ram_re, bus.resultado, bus.pronto, bus.ocupado, bus.db_estado);
        end
`ifdef LEITOR_LINHA_EN
        vectors++;
        if (linha_idx !== 3'd0 || linha_valida !== 1'b0) begin
            miscompares++;
            $display("FAIL meio_linha: got idx=%0d valida=%b, expected 0/0", linha_idx, linha_valida);
        end
`endif
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        pr_qtd = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            if (bus.pronto !== 1'b0 || bus.ram_re !== 1'b0) pr_qtd++;
        end
        vectors++;
        if (pr_qtd != 0) begin
            miscompares++;
            $display("FAIL meio_sem_pronto: got %0d active cycles after reset, expected 0", pr_qtd);
        end
        ler(4'd1, 0, 4'd0);
        for (int c = 1; c <= 9; c++) begin
            vectors++;
            if (re_log[c] !== 1'b1 || addr_log[c] !== 7'(9 + c - 1)) begin
                miscompares++;
                $display("FAIL meio_addr c%0d: got re=%b addr=%0d, expected re=1 addr=%0d", c, re_log[c], addr_log[c], 9 + c - 1);
            end
        end
        vectors++;
        if (pronto_ciclo != 12 || res_pronto !== 2'b10) begin
            miscompares++;
            $display("FAIL meio_resultado: got cycle %0d res=%b, expected cycle 12 res=10", pronto_ciclo, res_pronto);
        end
`ifdef LEITOR_LINHA_EN
        vectors++;
        if (linha_pronto !== 3'd3 || valida_pronto !== 1'b1) begin
            miscompares++;
            $display("FAIL meio_linha_nova: got idx=%0d valida=%b, expected 3/1", linha_pronto, valida_pronto);
        end
`endif
    endtask

    initial begin
        for (int a = 0; a <= 80; a++) mem[a] = 2'b00;
        // Board 0: XOXXOOOXX, full with no line.
        mem[0] = 2'b01; mem[1] = 2'b10; mem[2] = 2'b01;
        mem[3] = 2'b01; mem[4] = 2'b10; mem[5] = 2'b10;
        mem[6] = 2'b10; mem[7] = 2'b01; mem[8] = 2'b01;
        // Board 1: O column 0 (line 3), X at cells 1,2.
        mem[9] = 2'b10; mem[12] = 2'b10; mem[15] = 2'b10;
        mem[10] = 2'b01; mem[11] = 2'b01;
        // Board 2: X bottom row, a decoy for the ignored restart.
        mem[24] = 2'b01; mem[25] = 2'b01; mem[26] = 2'b01;
        // Board 3: O row 0 and X row 1, X must win on line 1.
        mem[27] = 2'b10; mem[28] = 2'b10; mem[29] = 2'b10;
        mem[30] = 2'b01; mem[31] = 2'b01; mem[32] = 2'b01;
        // Board 4: X top row.
        mem[36] = 2'b01; mem[37] = 2'b01; mem[38] = 2'b01;
        // Board 8: O anti-diagonal.
        mem[74] = 2'b10; mem[76] = 2'b10; mem[78] = 2'b10;

        test_reset();
        test_linha_x();
        test_linha_o();
        test_prioridade();
        test_indice_invalido();
        test_empate();
        test_inicio_ignorado();
        test_back_to_back();
        test_reset_meio();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/leitor_tabuleiro.md
# leitor_tabuleiro

Read-side companion to the game control FSM. On request it walks the nine cells of one micro board in the board RAM, captures them, and evaluates the eight tic-tac-toe lines. It returns a result code (none / X wins / O wins / draw) with a one-cycle `pronto` pulse. This result is what the control FSM writes into the board-state memory during its macro-verification step.

## Interface
- No parameters; all widths are fixed by the 9×9 board.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low; the block is held in reset while `reset`=0.
- `iniciar_leitura`  in  1  start request; sampled only in OCIOSO.
- `macro_idx`  in  4  micro board to read, 0–8, row-major; sampled with the accepted start.
- `ram_dado`  in  2  cell read from board RAM: 00 empty, 01 X, 10 O, 11 invalid (treated as empty).
- `ram_addr`  out  7  board RAM read address = macro_idx*9 + cell, range 0–80.
- `ram_re`  out  1  read enable; high while addresses are issued.
- `resultado`  out  2  00 none, 01 X wins, 10 O wins, 11 draw; held until the next accepted start.
- `pronto`  out  1  one-cycle pulse when `resultado` becomes valid.
- `ocupado`  out  1  high from the cycle after start acceptance through the PRONTO cycle.
- `db_estado`  out  4  current state code.

## Operation
- States and codes:
  - OCIOSO 0
  - LE 1
  - ULTIMA 2
  - AVALIA 3
  - PRONTO 4
  - Any other code forces OCIOSO, and `db_estado` then shows E.
- OCIOSO
  - If `iniciar_leitura`=1 and `macro_idx`≤8: latch `macro_idx`, clear cell counter `cnt` to 0, go to LE.
  - If `iniciar_leitura`=1 and `macro_idx`>8: force `resultado`=00 and go directly to PRONTO. No RAM reads occur.
- LE
  - Drive `ram_re`=1 and `ram_addr`=base+`cnt`.
  - The RAM has a one-cycle synchronous read. Data for the address issued in cycle c is captured at the end of cycle c+1 into cell register `cnt`−1.
  - When `cnt`=8, go to ULTIMA; otherwise increment `cnt`.
- ULTIMA: `ram_re`=0; capture cell 8 and go to AVALIA.
- AVALIA: register the evaluator output into `resultado` and go to PRONTO.
- PRONTO: `pronto`=1 and `ocupado`=1 for exactly one cycle, then return to OCIOSO.
- Line order:
  - Lines 0–2 are rows (0,1,2), (3,4,5), (6,7,8).
  - Lines 3–5 are columns (0,3,6), (1,4,7), (2,5,8).
  - Line 6 is (0,4,8); line 7 is (2,4,6).
- Evaluation priority:
  - Any X line gives 01. X wins over O if both are present, even though that is an illegal position.
  - Otherwise any O line gives 10.
  - Otherwise, if all nine cells are 01/10, the result is 11 (draw).
  - Otherwise 00.
- `iniciar_leitura` is ignored while not in OCIOSO. Changes to `macro_idx` after acceptance are ignored.
- The base address is computed as (idx<<3)+idx, with no multiplier.

## Timing
- Reset values:
  - state OCIOSO
  - `ram_addr`=0, `ram_re`=0
  - `resultado`=00, `pronto`=0, `ocupado`=0
  - `db_estado`=0
  - cell registers all 00
- Normal latency: if start is sampled at edge E0, LE occupies cycles 1–9, ULTIMA cycle 10, AVALIA cycle 11, and `pronto` is high in cycle 12.
- Invalid `macro_idx`: `pronto` is high in cycle 1.
- Back-to-back operation: a start asserted during the PRONTO cycle is ignored. The earliest accepted restart is the cycle after PRONTO, giving 13 cycles minimum per read.
- `resultado` changes only at the end of AVALIA, or on the invalid-index path. It is stable whenever `pronto`=1.
- Reset asserted mid-read returns the block immediately to its reset values. No partial result is produced.

## Configuration
- `LEITOR_LINHA_EN` defined: adds output ports `linha_idx`[2:0] and `linha_valida`[0:0], registered together with `resultado`.
  - `linha_idx` is the lowest-numbered winning line of the reported winner.
  - `linha_valida`=1 only when `resultado` is 01 or 10.
  - Both reset to 0.
- Not defined: these ports and their registers do not exist, and behaviour is otherwise identical.

## Structure
- Shared package holds:
  - cell encodings (VAZIO/X/O)
  - result encodings
  - state codes
  - the 8×3 line-to-cell table
  - the constant 9 (cells per board)
- Sub-module `avaliador_linhas`: purely combinational. It maps the 18-bit captured board to result, plus line index when `LEITOR_LINHA_EN` is defined. The FSM, address generation and capture stay in `leitor_tabuleiro`.

## Test plan
- `macro_idx`=4, cells X at 0,1,2 and the rest empty:
  - `ram_addr` must sequence 36..44 in cycles 1–9.
  - `resultado`=01 and `pronto` in cycle 12.
  - With `LEITOR_LINHA_EN`: `linha_idx`=0.
- `macro_idx`=8, O on cells 2,4,6 → addresses 72..80, `resultado`=10; with the macro: `linha_idx`=7.
- `macro_idx`=0, full board XOXXOOOXX (no line) → `resultado`=11. The same board with cell 8 changed to 11 (invalid code) → 00.
- `macro_idx`=9 → no `ram_re` pulse, `resultado`=00, `pronto` in cycle 1.
- Start pulsed again in cycle 5 with `macro_idx`=2 → ignored; the addresses still cover the original board.
- Reset dropped to 0 in cycle 6 and released → all outputs at reset values, no `pronto`. A new start with `macro_idx`=1 then gives addresses 9..17.
